gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
- Shares the single GPR write port between two writeback sources: ALU/exec and LSU (load data).
- Drives the register file's write interface: write enable, destination register, write data.
- Holds a pending-write scoreboard: decode marks a destination busy at issue, and the bit clears when that write reaches the register file. Decode uses the busy bits for RAW-hazard stalls.

Parameters:
- XLEN, 32, data width of writeback data and GPR write data
- NREG, 32, number of architectural registers; register-address width is fixed at 5

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_rd  in  5  LSU destination register
- lsu_data  in  XLEN  load result
- gpr_we  out  1  register-file write enable
- gpr_rd  out  5  register-file write address
- gpr_wdata  out  XLEN  register-file write data
- alloc_valid  in  1  decode issues an instruction writing alloc_rd
- alloc_rd  in  5  destination to mark pending
- rs1  in  5  hazard query address 1
- rs2  in  5  hazard query address 2
- rs1_busy  out  1  rs1 has a pending write
- rs2_busy  out  1  rs2 has a pending write
- flush  in  1  pipeline flush; clears the scoreboard

Behaviour:
- Reset: asynchronous, active-low rst_n; clock clk.
  - gpr_we=0, gpr_rd=0, gpr_wdata=0.
  - All busy bits 0; round-robin pointer favours ALU.
- Handshake:
  - A transfer occurs when xxx_valid && xxx_ready. At most one transfer per cycle.
  - ready is combinational from both valids and the arbitration state; ready never depends on ready.
  - A valid request that is not granted must hold valid, rd and data stable until it is granted.
- Arbitration:
  - One requester valid: that requester is granted.
  - Both valid: grant goes to the requester not granted at the most recent transfer.
  - The pointer updates only on a transfer.
- Latency:
  - Transfer in cycle N → gpr_we=1 with the registered rd and data in cycle N+1.
  - No transfer → gpr_we=0 next cycle; gpr_rd and gpr_wdata hold their last values.
- rd=0:
  - A transfer with rd=0 is accepted (ready asserted) but produces gpr_we=0.
  - busy[0] is never set, so rs1_busy and rs2_busy are always 0 for address 0.
- Scoreboard, one busy bit per register:
  - Set: alloc_valid with alloc_rd≠0 sets busy[alloc_rd] at the clock edge.
  - Clear: the cycle gpr_we=1 for register r, busy[r] clears at the end of that cycle.
  - Simultaneous set and clear of the same r in one cycle: set wins, because a new producer is pending.
  - rsX_busy = busy[rsX], read combinationally from registered state with no bypass from the same-cycle clear.
- Flush:
  - Clears all busy bits at the next edge. An alloc_valid in the same cycle is ignored.
  - Does not cancel a write already registered on gpr_we, and does not block transfers in the flush cycle.
  - Writes landing after a flush need no bookkeeping, since clearing an already-clear bit is a no-op.
- Reset asserted mid-operation: all state returns to reset values immediately; any pending output write is dropped.

Optional Feature:
- Macro: GPR_WB_RR_EN.
- Defined: round-robin arbitration as specified above.
- Undefined: fixed priority; LSU always wins when both are valid, no pointer state exists, and ALU may starve. Latency, scoreboard and rd=0 rules are unchanged.

Test Plan:
- alu_valid=1, alu_rd=5, alu_data=0x1234 alone → alu_ready=1 same cycle; next cycle gpr_we=1, gpr_rd=5, gpr_wdata=0x1234.
- Both valid for 4 cycles (ALU rd=1 data 0xA, LSU rd=2 data 0xB, held) with GPR_WB_RR_EN → grants alternate ALU, LSU, ALU, LSU. Without the macro → LSU granted all 4 cycles, alu_ready=0 throughout.
- alloc_valid, alloc_rd=7; then rs1=7 → rs1_busy=1. LSU writes rd=7; rs1_busy stays 1 in the gpr_we cycle and reads 0 the cycle after.
- Same cycle: alloc_rd=3 and gpr_we=1, gpr_rd=3 → busy[3] remains 1.
- ALU transfer with rd=0, data 0xFFFF → ready=1, next cycle gpr_we=0; alloc_rd=0 → rs1=0 busy stays 0.
- Set busy on 4 and 9, assert flush together with alloc_rd=12 → next cycle 4, 9 and 12 all read not busy. Drop rst_n mid-transfer → gpr_we=0 immediately, all busy bits 0.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the GPR write port between ALU and LSU writeback and keeps a pending-write scoreboard.
// Define GPR_WB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module gpr_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            gpr_we,
  output logic [4:0]      gpr_rd,
  output logic [XLEN-1:0] gpr_wdata,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            flush
);
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            gpr_we_q;
  logic [4:0]      gpr_rd_q;
  logic [XLEN-1:0] gpr_wdata_q;
  logic [NREG-1:0] busy_q, busy_d, clr, set;
`ifdef GPR_WB_RR_EN
  logic last_alu_q;
  assign alu_ready = alu_valid && (!lsu_valid || !last_alu_q);
  assign lsu_ready = lsu_valid && (!alu_valid || last_alu_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_alu_q <= 1'b0;
    else if (xfer) last_alu_q <= alu_ready;
`else
  assign alu_ready = alu_valid && !lsu_valid;
  assign lsu_ready = lsu_valid;
`endif
  assign xfer     = alu_ready || lsu_ready;
  assign sel_rd   = alu_ready ? alu_rd : lsu_rd;
  assign sel_data = alu_ready ? alu_data : lsu_data;
  // A new allocation outranks the retiring write to the same register.
  always_comb begin
    clr    = gpr_we_q ? NREG'(1) << gpr_rd_q : '0;
    set    = (alloc_valid && alloc_rd != 5'd0) ? NREG'(1) << alloc_rd : '0;
    busy_d = flush ? '0 : (busy_q & ~clr) | set;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gpr_we_q    <= 1'b0;
      gpr_rd_q    <= '0;
      gpr_wdata_q <= '0;
      busy_q      <= '0;
    end else begin
      gpr_we_q <= xfer && sel_rd != 5'd0;
      if (xfer) begin
        gpr_rd_q    <= sel_rd;
        gpr_wdata_q <= sel_data;
      end
      busy_q <= busy_d;
    end
  assign gpr_we    = gpr_we_q;
  assign gpr_rd    = gpr_rd_q;
  assign gpr_wdata = gpr_wdata_q;
  assign rs1_busy  = busy_q[rs1];
  assign rs2_busy  = busy_q[rs2];
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_gpr_wb_arbiter;
  localparam int XLEN = 32;
  logic            clk = 1'b0, rst_n = 1'b0;
  logic            alu_valid, lsu_valid, alloc_valid, flush;
  logic [4:0]      alu_rd, lsu_rd, alloc_rd, rs1, rs2, gpr_rd;
  logic [XLEN-1:0] alu_data, lsu_data, gpr_wdata;
  logic            alu_ready, lsu_ready, gpr_we, rs1_busy, rs2_busy;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .gpr_we(gpr_we), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush)
  );

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    alloc_valid = 0; alloc_rd = 0; rs1 = 0; rs2 = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rs1 = 5; rs2 = 9;
    @(negedge clk); #1;
    checks++; if (gpr_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", gpr_we); else passed++;
    checks++; if (gpr_rd !== 5'd0) $display("FAIL reset_rd got=%0d exp=0", gpr_rd); else passed++;
    checks++; if (gpr_wdata !== '0) $display("FAIL reset_wdata got=%0h exp=0", gpr_wdata); else passed++;
    checks++; if ({rs1_busy, rs2_busy} !== 2'b00) $display("FAIL reset_busy got=%b exp=00", {rs1_busy, rs2_busy}); else passed++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_alu_single();
    do_reset();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) $display("FAIL single_alu_ready got=%b exp=1", alu_ready); else passed++;
    checks++; if (lsu_ready !== 1'b0) $display("FAIL single_lsu_ready got=%b exp=0", lsu_ready); else passed++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (gpr_we !== 1'b1) $display("FAIL single_we got=%b exp=1", gpr_we); else passed++;
    checks++; if (gpr_rd !== 5'd5) $display("FAIL single_rd got=%0d exp=5", gpr_rd); else passed++;
    checks++; if (gpr_wdata !== 32'h1234) $display("FAIL single_wdata got=%0h exp=1234", gpr_wdata); else passed++;
    @(negedge clk); #1;
    checks++; if (gpr_we !== 1'b0) $display("FAIL single_we_drop got=%b exp=0", gpr_we); else passed++;
    checks++; if (gpr_rd !== 5'd5 || gpr_wdata !== 32'h1234)
      $display("FAIL single_hold got=%0d/%0h exp=5/1234", gpr_rd, gpr_wdata); else passed++;
  endtask

  task automatic test_both_valid();
    logic ea, prev_alu;
    do_reset();
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB;
    prev_alu = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef GPR_WB_RR_EN
      ea = (i % 2 == 0);
`else
      ea = 1'b0;
`endif
      #1;
      checks++; if (alu_ready !== ea) $display("FAIL both_alu_ready[%0d] got=%b exp=%b", i, alu_ready, ea); else passed++;
      checks++; if (lsu_ready !== !ea) $display("FAIL both_lsu_ready[%0d] got=%b exp=%b", i, lsu_ready, !ea); else passed++;
      if (i > 0) begin
        checks++; if (gpr_we !== 1'b1 || gpr_rd !== (prev_alu ? 5'd1 : 5'd2))
          $display("FAIL both_wb[%0d] got=%b/%0d exp=1/%0d", i, gpr_we, gpr_rd, prev_alu ? 1 : 2); else passed++;
      end
      prev_alu = ea;
      @(negedge clk);
    end
    idle();
    #1;
    checks++; if (gpr_wdata !== (prev_alu ? 32'hA : 32'hB))
      $display("FAIL both_last_wdata got=%0h exp=%0h", gpr_wdata, prev_alu ? 32'hA : 32'hB); else passed++;
  endtask

  task automatic test_scoreboard();
    do_reset();
    alloc_valid = 1; alloc_rd = 7; rs1 = 7;
    #1;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL sb_before_alloc got=%b exp=0", rs1_busy); else passed++;
    @(negedge clk);
    alloc_valid = 0;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    #1;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL sb_after_alloc got=%b exp=1", rs1_busy); else passed++;
    checks++; if (lsu_ready !== 1'b1) $display("FAIL sb_lsu_ready got=%b exp=1", lsu_ready); else passed++;
    @(negedge clk);
    lsu_valid = 0;
    #1;
    checks++; if (gpr_we !== 1'b1 || gpr_rd !== 5'd7) $display("FAIL sb_write got=%b/%0d exp=1/7", gpr_we, gpr_rd); else passed++;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL sb_busy_in_we_cycle got=%b exp=1", rs1_busy); else passed++;
    @(negedge clk); #1;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL sb_cleared got=%b exp=0", rs1_busy); else passed++;
  endtask

  task automatic test_set_clear_same();
    do_reset();
    alloc_valid = 1; alloc_rd = 3; rs1 = 3;
    @(negedge clk);
    alloc_valid = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    @(negedge clk);
    alu_valid = 0;
    alloc_valid = 1; alloc_rd = 3;
    #1;
    checks++; if (gpr_we !== 1'b1 || gpr_rd !== 5'd3) $display("FAIL same_write got=%b/%0d exp=1/3", gpr_we, gpr_rd); else passed++;
    @(negedge clk);
    alloc_valid = 0;
    #1;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL same_set_wins got=%b exp=1", rs1_busy); else passed++;
  endtask

  task automatic test_rd_zero();
    do_reset();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    alloc_valid = 1; alloc_rd = 0; rs1 = 0; rs2 = 0;
    #1;
    checks++; if (alu_ready !== 1'b1) $display("FAIL rd0_ready got=%b exp=1", alu_ready); else passed++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (gpr_we !== 1'b0) $display("FAIL rd0_we got=%b exp=0", gpr_we); else passed++;
    checks++; if ({rs1_busy, rs2_busy} !== 2'b00) $display("FAIL rd0_busy got=%b exp=00", {rs1_busy, rs2_busy}); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    alloc_valid = 1; alloc_rd = 4;
    @(negedge clk);
    alloc_rd = 9;
    @(negedge clk);
    alloc_valid = 0; rs1 = 4; rs2 = 9;
    #1;
    checks++; if ({rs1_busy, rs2_busy} !== 2'b11) $display("FAIL flush_pre_busy got=%b exp=11", {rs1_busy, rs2_busy}); else passed++;
    flush = 1; alloc_valid = 1; alloc_rd = 12;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    #1;
    checks++; if (alu_ready !== 1'b1) $display("FAIL flush_xfer_ready got=%b exp=1", alu_ready); else passed++;
    @(negedge clk);
    idle();
    rs1 = 4; rs2 = 9;
    #1;
    checks++; if ({rs1_busy, rs2_busy} !== 2'b00) $display("FAIL flush_cleared got=%b exp=00", {rs1_busy, rs2_busy}); else passed++;
    checks++; if (gpr_we !== 1'b1 || gpr_rd !== 5'd4) $display("FAIL flush_write got=%b/%0d exp=1/4", gpr_we, gpr_rd); else passed++;
    rs1 = 12;
    #1;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL flush_alloc_ignored got=%b exp=0", rs1_busy); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_valid = 1; alloc_rd = 5;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    @(negedge clk);
    idle();
    rs1 = 5;
    #1;
    checks++; if (gpr_we !== 1'b1 || rs1_busy !== 1'b1) $display("FAIL rstmid_pre got=%b/%b exp=1/1", gpr_we, rs1_busy); else passed++;
    rst_n = 0;
    #1;
    checks++; if (gpr_we !== 1'b0 || gpr_rd !== 5'd0 || gpr_wdata !== '0)
      $display("FAIL rstmid_out got=%b/%0d/%0h exp=0/0/0", gpr_we, gpr_rd, gpr_wdata); else passed++;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", rs1_busy); else passed++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    bit [31:0]       m_busy;
    bit              m_we, last_alu, a_hold, l_hold, ea, el;
    bit [4:0]        m_rd, wrd;
    bit [XLEN-1:0]   m_wd;
    do_reset();
    m_busy = 0; m_we = 0; m_rd = 0; m_wd = 0; last_alu = 0; a_hold = 0; l_hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!a_hold) begin
        alu_valid = $urandom_range(0, 1); alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      if (!l_hold) begin
        lsu_valid = $urandom_range(0, 1); lsu_rd = 5'($urandom_range(0, 31)); lsu_data = $urandom;
      end
      alloc_valid = ($urandom_range(0, 9) < 3);
      alloc_rd = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 19) == 0);
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      // Contention goes to whichever side did not win last; without round-robin the LSU always wins.
`ifdef GPR_WB_RR_EN
      ea = alu_valid && (!lsu_valid || !last_alu);
`else
      ea = alu_valid && !lsu_valid;
`endif
      el = lsu_valid && !ea;
      #1;
      checks++; if (alu_ready !== ea) $display("FAIL rnd_alu_ready[%0d] got=%b exp=%b", n, alu_ready, ea); else passed++;
      checks++; if (lsu_ready !== el) $display("FAIL rnd_lsu_ready[%0d] got=%b exp=%b", n, lsu_ready, el); else passed++;
      checks++; if (rs1_busy !== m_busy[rs1]) $display("FAIL rnd_rs1_busy[%0d] got=%b exp=%b", n, rs1_busy, m_busy[rs1]); else passed++;
      checks++; if (rs2_busy !== m_busy[rs2]) $display("FAIL rnd_rs2_busy[%0d] got=%b exp=%b", n, rs2_busy, m_busy[rs2]); else passed++;
      checks++; if (gpr_we !== m_we) $display("FAIL rnd_we[%0d] got=%b exp=%b", n, gpr_we, m_we); else passed++;
      if (m_we) begin
        checks++; if (gpr_rd !== m_rd || gpr_wdata !== m_wd)
          $display("FAIL rnd_wb[%0d] got=%0d/%0h exp=%0d/%0h", n, gpr_rd, gpr_wdata, m_rd, m_wd); else passed++;
      end
      if (flush) m_busy = 0;
      else begin
        if (m_we) m_busy[m_rd] = 1'b0;
        if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
      end
      wrd = ea ? alu_rd : lsu_rd;
      m_we = (ea || el) && wrd != 0;
      if (m_we) begin
        m_rd = wrd;
        m_wd = ea ? alu_data : lsu_data;
      end
      if (ea || el) last_alu = ea;
      a_hold = alu_valid && !ea;
      l_hold = lsu_valid && !el;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_single();
    test_both_valid();
    test_scoreboard();
    test_set_clear_same();
    test_rd_zero();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
